qld_w4q3_div_pipe: RTL

QLD_W4Q3_DIV_PIPE -- requirements
Module: qld_w4q3_div_pipe

---
 rtl/qld_pkg.sv | 33 +++
 rtl/qld_log8.sv | 26 ++
 rtl/qld_w4q3_div_pipe.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/qld_pkg.sv
// Shared widths, stage records and the ones'-complement magnitude helper
// for the log-domain 8-bit divider.
package qld_pkg;

    localparam int OPW  = 8;   // operand width
    localparam int LOGW = 6;   // {k[2:0], f[2:0]}
    localparam int DIFW = 7;   // log difference, two's complement
    localparam int MAGW = 12;  // antilog magnitude, Q8.4
    localparam int QW   = 13;  // ones'-complement signed quotient

    // Contents of stage 1: both logs plus the sign and zero flags.
    typedef struct packed {
        logic            sgn;
        logic            zx;
        logic            zy;
        logic [LOGW-1:0] lx;
        logic [LOGW-1:0] ly;
    } s1_rec_t;

    // Contents of stage 2: the log difference plus the flags carried along.
    typedef struct packed {
        logic            sgn;
        logic            zx;
        logic            zy;
        logic [DIFW-1:0] d;
    } s2_rec_t;

    // Ones'-complement magnitude: -1 maps to 0, -128 maps to 127.
    function automatic logic [OPW-1:0] oc_mag(input logic [OPW-1:0] v);
        return v ^ {OPW{v[OPW-1]}};
    endfunction

endpackage

// File: rtl/qld_log8.sv
// Log2 approximation of an 8-bit magnitude: leading-one index k and the
// three bits below it as fraction f (zero-padded on the right when k<3).
module qld_log8
    import qld_pkg::*;
(
    input  logic [OPW-1:0] i_mag,
    output logic           o_zero,
    output logic [2:0]     o_k,
    output logic [2:0]     o_f
);

    logic [OPW-1:0] w_norm;

    // Priority-encode the leading one, then normalise it to bit 7 so the
    // next three bits down are the fraction.
    always_comb begin
        o_k = 3'd0;
        for (int i = 0; i < OPW; i++) begin
            if (i_mag[i]) o_k = 3'(i);
        end
        w_norm = i_mag << (3'd7 - o_k);
        o_f    = w_norm[6:4];
        o_zero = (i_mag == '0);
    end

endmodule

// File: rtl/qld_w4q3_div_pipe.sv
// Three-stage log-domain divider: q ~= x / y in Q8.4 with a ones'-complement
// sign, plus a divide-by-zero flag.
//
// Handshake: a pair transfers on in_valid & in_ready, a result transfers on
// out_valid & out_ready. Each stage loads when it is empty or when the stage
// after it loads (the output register loads when empty or when it transfers),
// so in_ready never looks at in_valid and a full pipe with out_ready high
// still accepts a new pair. While out_valid & !out_ready, q/dz/out_valid hold.
module qld_w4q3_div_pipe
    import qld_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] x,
    input  logic [OPW-1:0] y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [QW-1:0]  q,
    output logic           dz
);

    logic          r_s1_valid;
    logic          r_s2_valid;
    logic          r_out_valid;
    s1_rec_t       r_s1;
    s2_rec_t       r_s2;
    logic [QW-1:0] r_q;
    logic          r_dz;

    logic          w_s1_load;
    logic          w_s2_load;
    logic          w_s3_load;

    logic [OPW-1:0] w_xmag;
    logic [OPW-1:0] w_ymag;
    logic           w_xzero;
    logic           w_yzero;
    logic [2:0]     w_xk;
    logic [2:0]     w_xf;
    logic [2:0]     w_yk;
    logic [2:0]     w_yf;
    s1_rec_t        w_s1_next;
    logic [DIFW-1:0] w_d;

    logic [3:0]      w_kd;
    logic [4:0]      w_s;
    logic [4:0]      w_rsh;
    logic [MAGW-1:0] w_wide;
    logic [MAGW-1:0] w_mag;
    logic [QW-1:0]   w_q;
    logic            w_dz;

    // Stage-advance chain, evaluated from the output backwards.
    assign w_s3_load = !r_out_valid | out_ready;
    assign w_s2_load = !r_s2_valid | w_s3_load;
    assign w_s1_load = !r_s1_valid | w_s2_load;
    assign in_ready  = w_s1_load;

    assign out_valid = r_out_valid;
    assign q         = r_q;
    assign dz        = r_dz;

    assign w_xmag = oc_mag(x);
    assign w_ymag = oc_mag(y);

    qld_log8 u_log_x (
        .i_mag  (w_xmag),
        .o_zero (w_xzero),
        .o_k    (w_xk),
        .o_f    (w_xf)
    );

    qld_log8 u_log_y (
        .i_mag  (w_ymag),
        .o_zero (w_yzero),
        .o_k    (w_yk),
        .o_f    (w_yf)
    );

    // Assemble the stage-1 record from both log converters.
    always_comb begin
        w_s1_next     = '0;
        w_s1_next.sgn = x[OPW-1] ^ y[OPW-1];
        w_s1_next.zx  = w_xzero;
        w_s1_next.zy  = w_yzero;
        w_s1_next.lx  = {w_xk, w_xf};
        w_s1_next.ly  = {w_yk, w_yf};
    end

    // Stage 1: capture logs, sign and zero flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            r_s1       <= w_s1_next;
        end
    end

    // Log difference widened to 7 bits so the full -63..63 range fits.
    assign w_d = {1'b0, r_s1.lx} - {1'b0, r_s1.ly};

    // Stage 2: capture the log difference.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2       <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            r_s2.sgn   <= r_s1.sgn;
            r_s2.zx    <= r_s1.zx;
            r_s2.zy    <= r_s1.zy;
            r_s2.d     <= w_d;
        end
    end

    // Antilog: {1,f_d} shifted by k_d+1 (left when non-negative, else right
    // with truncation), then sign and zero muxing; divisor zero wins.
    always_comb begin
        w_kd   = r_s2.d[6:3];
        w_s    = {w_kd[3], w_kd} + 5'd1;
        w_rsh  = 5'd0 - w_s;
        w_wide = {8'b0, 1'b1, r_s2.d[2:0]};
        w_mag  = '0;
        if (!w_s[4]) begin
            w_mag = w_wide << w_s[3:0];
        end else begin
            w_mag = w_wide >> w_rsh[3:0];
        end
        w_q  = {1'b0, w_mag} ^ {QW{r_s2.sgn}};
        w_dz = 1'b0;
        if (r_s2.zy) begin
            w_q  = '0;
            w_dz = 1'b1;
        end else if (r_s2.zx) begin
            w_q  = '0;
        end
    end

    // Stage 3: output register, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_q         <= '0;
            r_dz        <= 1'b0;
        end else if (w_s3_load) begin
            r_out_valid <= r_s2_valid;
            r_q         <= w_q;
            r_dz        <= w_dz;
        end
    end

endmodule
